ahb_spm_acc: RTL and testbench

Downstream stage of the bit-serial multiplier accelerator.
- Consumes the serial two's-complement product stream, one bit per cycle, LSB first.
- Deserializes each PW-bit product and accumulates it, sign-extended, into an ACC_W-bit accumulator.
- Exposes control, status and the accumulator as a word-addressed AHB-Lite slave on the same bus as the multiplier.

---
 rtl/spm_acc_pkg.sv | 24 ++
 rtl/spm_deser.sv | 74 +++++++
 rtl/ahb_spm_acc.sv | 170 +++++++++++++++++
 tb/tb_ahb_spm_acc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spm_acc_pkg.sv
// Shared constants for the serial-product accumulator: register offsets,
// CTRL/STATUS bit positions and deserializer state encodings.
package spm_acc_pkg;

  localparam logic [7:0] CTRL_OFF = 8'h00;
  localparam logic [7:0] STAT_OFF = 8'h04;
  localparam logic [7:0] ACCL_OFF = 8'h08;
  localparam logic [7:0] ACCM_OFF = 8'h0C;
  localparam logic [7:0] ACCH_OFF = 8'h10;

  localparam int CTRL_CLR = 0;
  localparam int CTRL_EN  = 1;
  localparam int CTRL_IE  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_ERR     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

endpackage

// File: rtl/spm_deser.sv
// Serial-to-parallel converter for LSB-first products: collects PW bits,
// hands the completed word over with a one-cycle add_pend strobe.
module spm_deser
  import spm_acc_pkg::*;
#(
  parameter int PW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          s_valid,
  input  logic          s_first,
  input  logic          s_bit,
  output logic [PW-1:0] word,
  output logic          add_pend,
  output logic          err_pulse,
  output logic [0:0]    state
);

  localparam int CW = $clog2(PW + 1);

  // Only PW-1 bits are buffered; the final bit is merged straight into word.
  logic [PW-2:0] sr;
  logic [CW-1:0] cnt;
  logic          last;

  assign last      = (cnt == CW'(PW - 1));
  assign err_pulse = (state == S_SHIFT) & s_valid & s_first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sr       <= '0;
      word     <= '0;
      add_pend <= 1'b0;
    end else begin
      add_pend <= 1'b0;
      if (clr) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (s_valid && s_first && en) begin
              sr    <= {s_bit, {(PW-2){1'b0}}};
              cnt   <= CW'(1);
              state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (s_valid) begin
              if (s_first) begin
                sr  <= {s_bit, {(PW-2){1'b0}}};
                cnt <= CW'(1);
              end else if (last) begin
                word     <= {s_bit, sr};
                add_pend <= 1'b1;
                cnt      <= '0;
                state    <= S_IDLE;
              end else begin
                sr  <= {s_bit, sr[PW-2:1]};
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ahb_spm_acc.sv
// AHB-Lite slave that accumulates sign-extended serial products into an
// ACC_W-bit accumulator, with a shadow for coherent multi-word reads.
module ahb_spm_acc
  import spm_acc_pkg::*;
#(
  parameter int PW    = 64,
  parameter int ACC_W = 80
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  input  logic        s_valid,
  input  logic        s_first,
  input  logic        s_bit,
  output logic        busy,
  output logic        irq
);

  localparam int SW = ACC_W - 32;

  logic [7:0]       addr_q;
  logic             wr_q;
  logic             rd_q;
  logic [7:0]       off;
  logic             access;
  logic             ctrl_en;
  logic             ctrl_ie;
  logic [ACC_W-1:0] acc;
  logic [SW-1:0]    shadow;
  logic             ovf;
  logic             done;
  logic             err;
  logic [7:0]       cnt;
  logic             clr;
  logic [PW-1:0]    word;
  logic             add_pend;
  logic             err_pulse;
  logic [0:0]       state;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_add;
  logic [31:0]      acch;
  logic             unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:8], HTRANS[0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;

  assign access = HSEL & HREADY & HTRANS[1];
  assign off    = {addr_q[7:2], 2'b00};
  assign clr    = wr_q & (off == CTRL_OFF) & HWDATA[CTRL_CLR];

  spm_deser #(.PW(PW)) u_deser (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .clr       (clr),
    .en        (ctrl_en),
    .s_valid   (s_valid),
    .s_first   (s_first),
    .s_bit     (s_bit),
    .word      (word),
    .add_pend  (add_pend),
    .err_pulse (err_pulse),
    .state     (state)
  );

  assign busy = (state == S_SHIFT) | add_pend;
  assign irq  = ctrl_ie & done;

  assign ext     = {{(ACC_W-PW){word[PW-1]}}, word};
  assign sum     = acc + ext;
  assign ovf_add = (acc[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != acc[ACC_W-1]);

  // Top word of the accumulator, taken from the shadow and sign-extended.
  if (ACC_W == 96) begin : g_acch_full
    assign acch = shadow[63:32];
  end else begin : g_acch_sext
    assign acch = {{(96-ACC_W){shadow[SW-1]}}, shadow[SW-1:32]};
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else if (HREADY) begin
      addr_q <= HADDR[7:0];
      wr_q   <= access & HWRITE;
      rd_q   <= access & ~HWRITE;
    end
  end

  // Priority, lowest to highest: W1C clears, add/error sets, CLR.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      acc     <= '0;
      shadow  <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      if (wr_q && off == CTRL_OFF) begin
        ctrl_en <= HWDATA[CTRL_EN];
        ctrl_ie <= HWDATA[CTRL_IE];
      end
      if (wr_q && off == STAT_OFF) begin
        if (HWDATA[STAT_OVF])  ovf  <= 1'b0;
        if (HWDATA[STAT_DONE]) done <= 1'b0;
        if (HWDATA[STAT_ERR])  err  <= 1'b0;
      end
      if (rd_q && off == ACCL_OFF) begin
        shadow <= acc[ACC_W-1:32];
      end
      if (add_pend) begin
        acc  <= sum;
        done <= 1'b1;
        if (ovf_add) ovf <= 1'b1;
        if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      end
      if (err_pulse) begin
        err <= 1'b1;
      end
      if (clr) begin
        acc    <= '0;
        shadow <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        done   <= 1'b0;
        err    <= 1'b0;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      case (off)
        CTRL_OFF: begin
          HRDATA[CTRL_EN] = ctrl_en;
          HRDATA[CTRL_IE] = ctrl_ie;
        end
        STAT_OFF: begin
          HRDATA[STAT_BUSY] = busy;
          HRDATA[STAT_OVF]  = ovf;
          HRDATA[STAT_DONE] = done;
          HRDATA[STAT_ERR]  = err;
          HRDATA[STAT_CNT_LSB +: 8] = cnt;
        end
        ACCL_OFF: HRDATA = acc[31:0];
        ACCM_OFF: HRDATA = shadow[31:0];
        ACCH_OFF: HRDATA = acch;
        default:  HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_spm_acc.sv
// Directed bench for ahb_spm_acc: single-product vector table plus
// hand-written multi-cycle sequences (back-to-back, abort, overflow, CLR race, coherence).
module tb_ahb_spm_acc;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        s_valid;
  logic        s_first;
  logic        s_bit;
  logic        busy;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_spm_acc #(.PW(64), .ACC_W(80)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .s_valid   (s_valid),
    .s_first   (s_first),
    .s_bit     (s_bit),
    .busy      (busy),
    .irq       (irq)
  );

  // Clock and reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [63:0] prod;
    logic        ie;
    logic [31:0] l;
    logic [31:0] m;
    logic [31:0] h;
    logic        irq;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    tick();
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int gap_a,
                           input int gap_b, input int gap_len);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_first = (i == 0);
      s_bit   = v[i];
      tick();
      s_valid = 1'b0;
      s_first = 1'b0;
      if (i == gap_a || i == gap_b) repeat (gap_len) tick();
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    check(name, d, exp);
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HSIZE = 3'b010;
    HWRITE = 1'b0; HADDR = '0; HWDATA = '0; s_valid = 1'b0; s_first = 1'b0; s_bit = 1'b0;

    vecs[0] = '{prod: 64'hFFFF_FFFF_FFFF_FED4, ie: 1'b1, l: 32'hFFFF_FED4, m: 32'hFFFF_FFFF, h: 32'hFFFF_FFFF, irq: 1'b1};
    vecs[1] = '{prod: 64'hFFFF_FFFF_FFFF_FED4, ie: 1'b0, l: 32'hFFFF_FED4, m: 32'hFFFF_FFFF, h: 32'hFFFF_FFFF, irq: 1'b0};
    vecs[2] = '{prod: 64'h0000_0001_2345_6789, ie: 1'b0, l: 32'h2345_6789, m: 32'h0000_0001, h: 32'h0000_0000, irq: 1'b0};
    vecs[3] = '{prod: 64'h8000_0000_0000_0000, ie: 1'b1, l: 32'h0000_0000, m: 32'h8000_0000, h: 32'hFFFF_FFFF, irq: 1'b1};
    vecs[4] = '{prod: 64'h7FFF_FFFF_FFFF_FFFF, ie: 1'b0, l: 32'hFFFF_FFFF, m: 32'h7FFF_FFFF, h: 32'h0000_0000, irq: 1'b0};

    // Reset behaviour
    repeat (3) tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    HRESETn = 1'b1;
    tick();
    check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("hresp", {30'b0, HRESP}, 32'd0);
    read_check("rst_status", 32'h04, 32'h0000_0000);
    read_check("rst_ctrl", 32'h00, 32'h0000_0000);

    // EN=0 ignores a product
    ahb_write(32'h00, 32'h1);
    send_bits(64'd5, 64, -1, -1, 0);
    tick();
    read_check("noen_accl", 32'h08, 32'h0);
    read_check("noen_status", 32'h04, 32'h0);
    ahb_write(32'h00, 32'h7);
    read_check("ctrl_rb", 32'h00, 32'h6);
    read_check("unmapped", 32'h14, 32'h0);

    // Table-driven single products
    for (int k = 0; k < 5; k++) begin
      ahb_write(32'h00, {29'b0, vecs[k].ie, 2'b11});
      send_bits(vecs[k].prod, 64, -1, -1, 0);
      tick();
      check($sformatf("v%0d_irq", k), {31'b0, irq}, {31'b0, vecs[k].irq});
      read_check($sformatf("v%0d_status", k), 32'h04, 32'h0000_0104);
      read_check($sformatf("v%0d_accl", k), 32'h08, vecs[k].l);
      read_check($sformatf("v%0d_accm", k), 32'h0C, vecs[k].m);
      read_check($sformatf("v%0d_acch", k), 32'h10, vecs[k].h);
    end

    // Back-to-back 5 and 7 with mid-stream gaps
    ahb_write(32'h00, 32'h3);
    send_bits(64'd5, 64, 10, 40, 3);
    send_bits(64'd7, 64, 20, -1, 3);
    tick();
    read_check("b2b_status", 32'h04, 32'h0000_0204);
    read_check("b2b_accl", 32'h08, 32'd12);
    read_check("b2b_accm", 32'h0C, 32'd0);

    // Abort after 20 bits, then product 3
    ahb_write(32'h00, 32'h3);
    send_bits(64'hDEAD_BEEF_1234_5678, 20, -1, -1, 0);
    check("abort_busy", {31'b0, busy}, 32'd1);
    send_bits(64'd3, 64, -1, -1, 0);
    tick();
    read_check("abort_status", 32'h04, 32'h0000_010C);
    read_check("abort_accl", 32'h08, 32'd3);
    ahb_write(32'h04, 32'hE);
    read_check("w1c_status", 32'h04, 32'h0000_0100);

    // Overflow: preload 2^79-1, add 1
    ahb_write(32'h00, 32'h3);
    force dut.acc = 80'h7FFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.acc;
    send_bits(64'd1, 64, -1, -1, 0);
    tick();
    read_check("ovf_status", 32'h04, 32'h0000_0106);
    read_check("ovf_accl", 32'h08, 32'h0000_0000);
    read_check("ovf_accm", 32'h0C, 32'h0000_0000);
    read_check("ovf_acch", 32'h10, 32'hFFFF_8000);

    // CLR lands in the add cycle of product 9
    ahb_write(32'h00, 32'h3);
    send_bits(64'd9, 63, -1, -1, 0);
    s_valid = 1'b1; s_first = 1'b0; s_bit = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
    tick();
    s_valid = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h3;
    tick();
    check("clr_busy", {31'b0, busy}, 32'd0);
    read_check("clr_status", 32'h04, 32'h0000_0000);
    read_check("clr_accl", 32'h08, 32'h0);
    read_check("clr_accm", 32'h0C, 32'h0);

    // Coherence: shadow keeps the upper word captured by the 0x08 read
    ahb_write(32'h00, 32'h3);
    send_bits(64'h0000_0001_0000_0000, 64, -1, -1, 0);
    tick();
    read_check("coh_accl", 32'h08, 32'h0);
    send_bits(64'h0000_0001_0000_0000, 64, -1, -1, 0);
    tick();
    read_check("coh_accm_old", 32'h0C, 32'h1);
    read_check("coh_accl2", 32'h08, 32'h0);
    read_check("coh_accm_new", 32'h0C, 32'h2);
    read_check("coh_status", 32'h04, 32'h0000_0204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
